pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the processor's single-cycle 32-bit adder.
- Splits a WIDTH-bit add/subtract into STAGES equal segments, one segment per clock, with the carry registered between segments.
- Produces sum, carry, signed overflow and zero flags behind a valid/ready handshake with full backpressure.
- Used by the ALU and the branch-target path where a shorter critical path is needed.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline segments (>=1); SEG = WIDTH/STAGES bits per segment.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  0 = a+b+cin; 1 = a-b (computed as a+~b+1, cin ignored)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- carry  output  1  carry-out of MSB (sub: 1 = no borrow)
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)
- zero  output  1  sum == 0

Behaviour:
- Reset (rst_n low at a clk edge):
  - All stage valid bits, partial sums, carries and skewed operand copies clear to 0.
  - Outputs after reset: out_valid=0, sum=0, carry=0, overflow=0, zero=0.
  - in_ready=1 in the first cycle after reset is released.
  - Reset mid-operation discards every in-flight operation; nothing is emitted afterwards.
- Advance enable: adv = !out_valid || out_ready. The whole pipeline shifts only when adv=1 (global stall; bubbles are not compressed). in_ready = adv.
- Accept: a transfer occurs when in_valid && in_ready. The effective B (b or ~b) and the effective carry-in (cin or 1) are captured at accept time.
- Stage k (0..STAGES-1):
  - Adds segment k of a and eff_b plus the carry from stage k-1 (stage 0 uses the effective carry-in).
  - Registers the SEG-bit partial sum and the segment carry-out.
  - Carries the still-unprocessed upper segments of a and eff_b forward in skew registers.
  - Lower completed partial sums travel with the operation.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1, when unstalled. Throughput is 1 result per cycle.
- Output stage:
  - carry = final segment carry-out.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. This is meaningful for both add and sub.
  - zero = (sum == 0), registered alongside sum.
- Hold: while out_valid && !out_ready, sum/carry/overflow/zero and all internal stages stay stable, and in_ready=0.
- A bubble (accept cycle with in_valid=0) propagates as valid=0 and leaves the data registers don't-care. Outputs are sampled only when out_valid=1.
- Simultaneous events: a new accept and an output drain in the same cycle are legal; order is strictly FIFO.
- STAGES=1 degenerates to a single registered adder with latency 1.
- No wrap detection beyond carry/overflow: results are modulo 2^WIDTH.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, all flags 0; in_ready=1 after release.
- Add wrap: a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> out_valid exactly 4 cycles after accept, sum=0x00000000, carry=1, zero=1, overflow=0.
- Subtract:
  - 5-7 -> sum=0xFFFFFFFE, carry=0, overflow=0.
  - 0x80000000-1 -> sum=0x7FFFFFFF, carry=1, overflow=1.
  - 0x7FFFFFFF+1 (add) -> sum=0x80000000, overflow=1.
- Streaming: 8 back-to-back random operations with out_ready=1 -> 8 results on consecutive cycles, in order, each matching a golden model (a±b with carry/overflow/zero).
- Backpressure: drop out_ready for 3 cycles while results are pending -> in_ready=0, sum/flags held constant, no result lost or duplicated after out_ready returns.
- Mid-flight reset and STAGES=1/STAGES=8, WIDTH=64 builds:
  - Reset with 3 operations in flight -> no out_valid afterwards.
  - Parametric builds pass the same golden checks with latency equal to STAGES.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit segment per stage, carry
// registered between segments, valid/ready handshake with a global stall.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned SEGC = SEG + 1;

    logic adv;

    // Stage registers: valid, accumulated partial sum, segment carry-out and
    // the operands right-shifted so the next segment to add sits at bit 0.
    logic             st_v   [STAGES];
    logic             st_c   [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];

    logic             nx_v   [STAGES];
    logic             nx_c   [STAGES];
    logic [WIDTH-1:0] nx_sum [STAGES];
    logic [WIDTH-1:0] nx_a   [STAGES];
    logic [WIDTH-1:0] nx_b   [STAGES];

    logic ovf_r;
    logic zero_r;
    logic nx_ovf;
    logic nx_zero;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic [SEG:0]     seg_add;

        if (k == 0) begin : g_first
            // Subtract folds into a + ~b + 1; cin only matters in add mode.
            assign v_in   = in_valid;
            assign a_in   = a;
            assign b_in   = sub ? ~b : b;
            assign c_in   = sub | cin;
            assign sum_in = '0;
        end else begin : g_next
            assign v_in   = st_v[k-1];
            assign a_in   = st_a[k-1];
            assign b_in   = st_b[k-1];
            assign c_in   = st_c[k-1];
            assign sum_in = st_sum[k-1];
        end

        assign seg_add = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + SEGC'(c_in);

        assign nx_v[k]   = v_in;
        assign nx_c[k]   = seg_add[SEG];
        assign nx_a[k]   = a_in >> SEG;
        assign nx_b[k]   = b_in >> SEG;
        // Segment k of sum_in is still zero, so OR-ing inserts the new segment.
        assign nx_sum[k] = sum_in | (WIDTH'(seg_add[SEG-1:0]) << (k * SEG));

        if (k == STAGES - 1) begin : g_last
            // Carry into the MSB recovered from the MSB sum bit and its operands.
            assign nx_ovf  = seg_add[SEG] ^ (seg_add[SEG-1] ^ a_in[SEG-1] ^ b_in[SEG-1]);
            assign nx_zero = (nx_sum[k] == '0);
        end
    end

    // Whole pipeline shifts together; a stalled output freezes every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_v[k]   <= 1'b0;
                st_c[k]   <= 1'b0;
                st_sum[k] <= '0;
                st_a[k]   <= '0;
                st_b[k]   <= '0;
            end
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_v[k]   <= nx_v[k];
                st_c[k]   <= nx_c[k];
                st_sum[k] <= nx_sum[k];
                st_a[k]   <= nx_a[k];
                st_b[k]   <= nx_b[k];
            end
            ovf_r  <= nx_ovf;
            zero_r <= nx_zero;
        end
    end

    assign out_valid = st_v[STAGES-1];
    assign sum       = st_sum[STAGES-1];
    assign carry     = st_c[STAGES-1];
    assign overflow  = ovf_r;
    assign zero      = zero_r;

endmodule
